// File: rtl/dmem_access_ctrl.sv
// Initiator-side controller for the 8-bit data memory port: accepts load/store
// requests over valid/ready and sequences single or burst beats onto mem_rd/mem_wrt.
module dmem_access_ctrl #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [1:0] req_len,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       busy,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_rd,
  output logic       mem_wrt,
  input  logic [7:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  state_t     state, state_nx;
  logic [7:0] cur_addr, cur_addr_nx;
  logic [7:0] wdata_q, wdata_nx;
  logic [1:0] beats_q, beats_nx;
  logic [1:0] wait_q, wait_nx;
  logic       mem_rd_nx, mem_wrt_nx;
  logic [7:0] mem_addr_nx, mem_data_nx, rsp_data_nx;
  logic       rsp_valid_nx, rsp_last_nx;
  logic       accept, wait_done, last_beat;

  assign req_ready = (state == IDLE) & ~rst;
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;
  assign wait_done = (wait_q == LAST_WAIT);
  assign last_beat = (beats_q == 2'd0);

  // State register plus registered strobes/datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      wdata_q   <= '0;
      beats_q   <= '0;
      wait_q    <= '0;
      mem_rd    <= 1'b0;
      mem_wrt   <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_addr  <= cur_addr_nx;
      wdata_q   <= wdata_nx;
      beats_q   <= beats_nx;
      wait_q    <= wait_nx;
      mem_rd    <= mem_rd_nx;
      mem_wrt   <= mem_wrt_nx;
      mem_addr  <= mem_addr_nx;
      mem_data  <= mem_data_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_data  <= rsp_data_nx;
      rsp_last  <= rsp_last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = req_we ? WR : RD;
      RD:      if (wait_done && last_beat) state_nx = IDLE;
      WR:      if (last_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are computed one cycle ahead so they appear registered in the beat's cycle
  always_comb begin
    cur_addr_nx  = cur_addr;
    wdata_nx     = wdata_q;
    beats_nx     = beats_q;
    wait_nx      = wait_q;
    mem_rd_nx    = 1'b0;
    mem_wrt_nx   = 1'b0;
    mem_addr_nx  = mem_addr;
    mem_data_nx  = mem_data;
    rsp_valid_nx = 1'b0;
    rsp_data_nx  = rsp_data;
    rsp_last_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cur_addr_nx = req_addr;
          wdata_nx    = req_wdata;
          beats_nx    = req_len;
          wait_nx     = '0;
          mem_addr_nx = req_addr;
          if (req_we) begin
            mem_wrt_nx  = 1'b1;
            mem_data_nx = req_wdata;
          end else begin
            mem_rd_nx = 1'b1;
          end
        end
      end
      RD: begin
        mem_rd_nx = 1'b1;
        if (!wait_done) begin
          wait_nx = wait_q + 2'd1;
        end else begin
          rsp_valid_nx = 1'b1;
          rsp_data_nx  = mem_rd_data;
          rsp_last_nx  = last_beat;
          wait_nx      = '0;
          if (last_beat) begin
            mem_rd_nx = 1'b0;
          end else begin
            cur_addr_nx = cur_addr + 8'd1;
            mem_addr_nx = cur_addr + 8'd1;
            beats_nx    = beats_q - 2'd1;
          end
        end
      end
      WR: begin
        if (last_beat) begin
          rsp_valid_nx = 1'b1;
          rsp_last_nx  = 1'b1;
          rsp_data_nx  = '0;
        end else begin
          mem_wrt_nx  = 1'b1;
          cur_addr_nx = cur_addr + 8'd1;
          mem_addr_nx = cur_addr + 8'd1;
          mem_data_nx = wdata_q;
          beats_nx    = beats_q - 2'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a cycle table on an RD_LAT=1 instance,
// plus hand sequences for an RD_LAT=3 burst and a reset in the middle of a store.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_we;
  logic [7:0] req_addr, req_wdata;
  logic [1:0] req_len;

  logic       v1, rdy1, rv1, rl1, busy1, rd1, wrt1;
  logic [7:0] rdat1, ma1, md1, mrd1;
  logic       v3, rdy3, rv3, rl3, busy3, rd3, wrt3;
  logic [7:0] rdat3, ma3, md3, mrd3;

  // Memory model: 0x10 holds 0x5A, everything else returns ~addr
  assign mrd1 = (ma1 == 8'h10) ? 8'h5A : ~ma1;
  assign mrd3 = (ma3 == 8'h10) ? 8'h5A : ~ma3;

  dmem_access_ctrl #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rv1), .rsp_data(rdat1), .rsp_last(rl1), .busy(busy1),
    .mem_addr(ma1), .mem_data(md1), .mem_rd(rd1), .mem_wrt(wrt1), .mem_rd_data(mrd1));

  dmem_access_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rv3), .rsp_data(rdat3), .rsp_last(rl3), .busy(busy3),
    .mem_addr(ma3), .mem_data(md3), .mem_rd(rd3), .mem_wrt(wrt3), .mem_rd_data(mrd3));

  typedef struct {
    logic       rst, valid, we;
    logic [7:0] addr, wdata;
    logic [1:0] len;
    logic       e_ready, e_busy, e_rd, e_wrt;
    logic [7:0] e_maddr, e_mdata;
    logic       e_rv;
    logic [7:0] e_rdata;
    logic       e_rl;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %02h expected %02h", name, cyc, act, exp);
    end
  endtask

  vec_t vt[13];

  initial begin
    //           rst v  we addr   wdata  len  rdy bsy rd wrt maddr  mdata  rv rdata  rl
    vt[0]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,2'd0, 1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,1'b0};
    vt[1]  = '{1'b0,1'b1,1'b0,8'h10,8'h00,2'd0, 1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,1'b0};
    vt[2]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,2'd0, 1'b0,1'b1,1'b1,1'b0,8'h10,8'h00,1'b0,8'h00,1'b0};
    vt[3]  = '{1'b0,1'b1,1'b1,8'hFE,8'hC3,2'd3, 1'b1,1'b0,1'b0,1'b0,8'h10,8'h00,1'b1,8'h5A,1'b1};
    vt[4]  = '{1'b0,1'b0,1'b0,8'h55,8'hAA,2'd1, 1'b0,1'b1,1'b0,1'b1,8'hFE,8'hC3,1'b0,8'h5A,1'b0};
    vt[5]  = '{1'b0,1'b1,1'b0,8'h12,8'h34,2'd2, 1'b0,1'b1,1'b0,1'b1,8'hFF,8'hC3,1'b0,8'h5A,1'b0};
    vt[6]  = '{1'b0,1'b0,1'b1,8'h77,8'h88,2'd0, 1'b0,1'b1,1'b0,1'b1,8'h00,8'hC3,1'b0,8'h5A,1'b0};
    vt[7]  = '{1'b0,1'b1,1'b1,8'h99,8'h11,2'd3, 1'b0,1'b1,1'b0,1'b1,8'h01,8'hC3,1'b0,8'h5A,1'b0};
    vt[8]  = '{1'b0,1'b1,1'b0,8'h20,8'h66,2'd1, 1'b1,1'b0,1'b0,1'b0,8'h01,8'hC3,1'b1,8'h00,1'b1};
    vt[9]  = '{1'b0,1'b0,1'b1,8'hE0,8'h01,2'd3, 1'b0,1'b1,1'b1,1'b0,8'h20,8'hC3,1'b0,8'h00,1'b0};
    vt[10] = '{1'b0,1'b1,1'b1,8'h33,8'h02,2'd3, 1'b0,1'b1,1'b1,1'b0,8'h21,8'hC3,1'b1,8'hDF,1'b0};
    vt[11] = '{1'b0,1'b0,1'b0,8'h00,8'h00,2'd0, 1'b1,1'b0,1'b0,1'b0,8'h21,8'hC3,1'b1,8'hDE,1'b1};
    vt[12] = '{1'b0,1'b0,1'b0,8'h00,8'h00,2'd0, 1'b1,1'b0,1'b0,1'b0,8'h21,8'hC3,1'b0,8'hDE,1'b0};

    rst = 1'b1; v1 = 1'b0; v3 = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_len = '0;
    repeat (2) @(posedge clk);

    // Cycle table on the RD_LAT=1 instance
    for (int unsigned i = 0; i < 13; i++) begin
      @(negedge clk);
      rst = vt[i].rst; v1 = vt[i].valid; req_we = vt[i].we;
      req_addr = vt[i].addr; req_wdata = vt[i].wdata; req_len = vt[i].len;
      #1;
      chk("req_ready", i, {7'd0, rdy1}, {7'd0, vt[i].e_ready});
      chk("busy",      i, {7'd0, busy1}, {7'd0, vt[i].e_busy});
      chk("mem_rd",    i, {7'd0, rd1}, {7'd0, vt[i].e_rd});
      chk("mem_wrt",   i, {7'd0, wrt1}, {7'd0, vt[i].e_wrt});
      chk("mem_addr",  i, ma1, vt[i].e_maddr);
      chk("mem_data",  i, md1, vt[i].e_mdata);
      chk("rsp_valid", i, {7'd0, rv1}, {7'd0, vt[i].e_rv});
      chk("rsp_data",  i, rdat1, vt[i].e_rdata);
      chk("rsp_last",  i, {7'd0, rl1}, {7'd0, vt[i].e_rl});
    end

    // RD_LAT=3 burst: 3 beats from 0x40, responses BF/BE/BD in cycles 4/7/10
    @(negedge clk);
    v3 = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_len = 2'd2; req_wdata = 8'h00;
    #1 chk("rd3_ready", 0, {7'd0, rdy3}, 8'd1);
    for (int unsigned c = 1; c <= 12; c++) begin
      logic       e_rd, e_rv, e_rl;
      logic [7:0] e_addr;
      @(negedge clk);
      v3 = 1'b0; req_addr = 8'(c * 37); req_wdata = 8'(c);
      #1;
      e_rd   = (c >= 1 && c <= 9);
      e_rv   = (c == 4 || c == 7 || c == 10);
      e_rl   = (c == 10);
      e_addr = (c > 9) ? 8'h42 : 8'(8'h40 + (c - 1) / 3);
      chk("rd3_mem_rd",   c, {7'd0, rd3}, {7'd0, e_rd});
      chk("rd3_mem_wrt",  c, {7'd0, wrt3}, 8'd0);
      chk("rd3_mem_addr", c, ma3, e_addr);
      chk("rd3_rsp_valid", c, {7'd0, rv3}, {7'd0, e_rv});
      chk("rd3_rsp_last", c, {7'd0, rl3}, {7'd0, e_rl});
      if (e_rv) chk("rd3_rsp_data", c, rdat3, ~(8'h40 + 8'((c - 4) / 3)));
      chk("rd3_busy", c, {7'd0, busy3}, {7'd0, (c <= 9) ? 1'b1 : 1'b0});
    end

    // Reset during cycle 2 of a 4-beat store on the RD_LAT=1 instance
    @(negedge clk);
    v1 = 1'b1; req_we = 1'b1; req_addr = 8'h80; req_wdata = 8'h5C; req_len = 2'd3;
    for (int unsigned c = 1; c <= 7; c++) begin
      @(negedge clk);
      v1 = 1'b0;
      rst = (c == 2);
      #1;
      if (c <= 2) begin
        chk("rstb_mem_wrt",  c, {7'd0, wrt1}, 8'd1);
        chk("rstb_mem_addr", c, ma1, 8'(8'h80 + c - 1));
        chk("rstb_ready",    c, {7'd0, rdy1}, 8'd0);
      end else begin
        chk("rstb_mem_wrt",   c, {7'd0, wrt1}, 8'd0);
        chk("rstb_rsp_valid", c, {7'd0, rv1}, 8'd0);
        chk("rstb_busy",      c, {7'd0, busy1}, 8'd0);
        chk("rstb_ready",     c, {7'd0, rdy1}, 8'd1);
        chk("rstb_mem_addr",  c, ma1, 8'h00);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Strobe exclusivity on both instances throughout the run
  always @(negedge clk) begin
    if ((rd1 & wrt1) === 1'b1 || (rd3 & wrt3) === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap: rd1=%b wrt1=%b rd3=%b wrt3=%b required not both high", rd1, wrt1, rd3, wrt3);
    end
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Initiator-side controller for the 8-bit data memory port. It accepts load/store requests from the datapath over a valid/ready handshake and sequences single or burst accesses onto the memory strobes (`mem_rd`, `mem_wrt`). It returns read bytes and completion over a one-cycle response interface. It sits between the execute stage and DMEM and owns every memory strobe in the design.

## Interface
- `RD_LAT`, default 1, legal 1..4. Number of cycles `mem_rd` is held per read beat; `mem_rd_data` is sampled at the end of the last of these cycles.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 8: start address.
- `req_wdata` in 8: store byte. A store burst writes this byte to every beat (fill).
- `req_len` in 2: beats minus one (0..3 → 1..4 beats).
- `rsp_valid` out 1: one-cycle pulse; read beat data, or store completion.
- `rsp_data` out 8: read byte; 0x00 for store completion.
- `rsp_last` out 1: final response of the request.
- `busy` out 1: request in progress (state ≠ IDLE).
- `mem_addr` out 8, `mem_data` out 8, `mem_rd` out 1, `mem_wrt` out 1: registered memory-side strobes and address/data.
- `mem_rd_data` in 8: read data from memory.

## Operation
- States: IDLE, RD, WR.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid & req_ready`: latch addr, wdata, `beats = req_len + 1`, and we.
  - Go to RD if we = 0, otherwise to WR.
- **WR**
  - One beat per cycle: `mem_wrt` = 1, `mem_addr` = cur_addr, `mem_data` = wdata.
  - After each beat: cur_addr = cur_addr + 1 mod 256, then decrement the beat count.
  - After the final beat: go to IDLE. In the next cycle, `rsp_valid` = 1, `rsp_last` = 1, `rsp_data` = 0x00.
  - No response is issued for intermediate store beats.
- **RD**
  - `mem_rd` = 1 and `mem_addr` = cur_addr, held for RD_LAT cycles (wait counter 0..RD_LAT-1).
  - On the last wait cycle, capture `mem_rd_data` into `rsp_data`. Pulse `rsp_valid` the following cycle, with `rsp_last` = 1 on the final beat.
  - Then advance cur_addr (mod 256) and start the next beat immediately.
  - `mem_rd` stays high across beats; only `mem_addr` changes.
  - After the final beat: go to IDLE.
- Address arithmetic is 8-bit unsigned; 0xFF + 1 wraps to 0x00 inside a burst, with no error.
- `mem_rd` and `mem_wrt` are never high in the same cycle.
- In IDLE, `mem_rd` and `mem_wrt` are 0. `mem_addr` and `mem_data` hold their last values.
- `req_ready` = (state == IDLE) & ~`rst`.
- A request accepted in the same cycle as the previous request's final `rsp_valid` is legal; back-to-back requests have no bubble beyond the IDLE acceptance cycle.

## Timing
- Reset (synchronous, `rst` high at the clock edge):
  - state = IDLE.
  - Outputs: `mem_rd` = 0, `mem_wrt` = 0, `mem_addr` = 0x00, `mem_data` = 0x00, `rsp_valid` = 0, `rsp_data` = 0x00, `rsp_last` = 0, `busy` = 0.
  - `req_ready` = 0 while `rst` is high; it is 1 in the first cycle after `rst` deasserts.
- Reset mid-burst: the burst is abandoned and no further strobes or responses are issued. Strobes are low in the cycle after the reset edge.
- Read latency, handshake at cycle 0:
  - First `mem_rd` in cycle 1.
  - First `rsp_valid` in cycle 1 + RD_LAT.
  - An N-beat read ends with `rsp_last` at cycle N·RD_LAT + 1.
- Store latency, handshake at cycle 0:
  - `mem_wrt` in cycles 1..N.
  - `rsp_valid` + `rsp_last` in cycle N + 1.
- `req_*` inputs are sampled only at handshake; changes during `busy` are ignored.

## Test plan
- Reset, then load with addr 0x10, len 0, RD_LAT 1, memory returning 0x5A → `mem_rd` high in cycle 1 with `mem_addr` 0x10; `rsp_valid`/`rsp_last` in cycle 2 with `rsp_data` 0x5A; `busy` low in cycle 2.
- Store fill with addr 0xFE, len 3, wdata 0xC3 → `mem_wrt` in cycles 1–4 at addresses FE, FF, 00, 01 with `mem_data` C3; a single `rsp_valid` + `rsp_last` in cycle 5 with `rsp_data` 0x00.
- Load burst with len 2, RD_LAT 3, addr 0x40, memory model returning addr^0xFF → responses BF, BE, BD in cycles 4, 7, 10; `rsp_last` only in cycle 10; `mem_rd` continuously high in cycles 1–9.
- Back-to-back requests: load issued in the same cycle as the previous store's `rsp_last` → accepted; no overlap of `mem_rd`/`mem_wrt`; `req_ready` low while `busy`.
- `rst` asserted in cycle 2 of a 4-beat store → no `mem_wrt` after the reset edge, no `rsp_valid`; `req_ready` high in the cycle after `rst` drops.
- `req_addr`/`req_wdata` toggled every cycle while `busy` → burst addresses and data are unaffected.
